// File: rtl/usi_slave_csr.sv
// usi_slave_csr: USI bus slave endpoint with a bank of RW CSRs,
// a read-only status word and an optional interrupt block.
// Ports: iSysClk/iSysRst clock and sync reset; iSUsiWd/iSUsiAdrs/iSUsiWCke
// master command; oSUsiRd/oSUsiVd read response; oCsrQ/oCsrWe CSR contents
// and write strobes; iStatus status word (0x0080); iIrqSrc/oIrq interrupts.
// Build option: define USI_SLAVE_IRQ_EN for IRQ status (0x0081) and mask (0x0082).
module usi_slave_csr #(
   parameter logic [7:0] pBusAdrs = 8'h01,
   parameter int          pCsrNum  = 8,
   parameter int          pIrqNum  = 4
) (
   input  logic                   iSysClk,
   input  logic                   iSysRst,
   input  logic [31:0]            iSUsiWd,
   input  logic [31:0]            iSUsiAdrs,
   input  logic                   iSUsiWCke,
   output logic [31:0]            oSUsiRd,
   output logic                   oSUsiVd,
   output logic [32*pCsrNum-1:0]  oCsrQ,
   output logic [pCsrNum-1:0]     oCsrWe,
   input  logic [31:0]            iStatus,
   input  logic [pIrqNum-1:0]     iIrqSrc,
   output logic                   oIrq
);

   localparam logic [15:0] lpStsAdr    = 16'h0080;
   localparam logic [15:0] lpIrqStsAdr = 16'h0081;
   localparam logic [15:0] lpIrqMskAdr = 16'h0082;

   logic [1:0]  w_cmd;
   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic [31:0] w_rdata;
   logic        w_unused;

   logic        r_s1_vld;
   logic        r_s1_wr;
   logic [15:0] r_s1_adr;
   logic [31:0] r_s1_wd;

   logic [31:0]        r_csr [pCsrNum];
   logic [pCsrNum-1:0] r_we;
   logic [31:0]        r_rd;
   logic               r_vd;

   assign w_cmd = iSUsiAdrs[31:30];
   // Only write (1) and read (2) for our bus address enter the pipe.
   assign w_hit = iSUsiWCke
                & ((w_cmd == 2'd1) | (w_cmd == 2'd2))
                & (iSUsiAdrs[23:16] == pBusAdrs);

   always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
         r_s1_vld <= 1'b0;
         r_s1_wr  <= 1'b0;
         r_s1_adr <= '0;
         r_s1_wd  <= '0;
      end else begin
         r_s1_vld <= w_hit;
         r_s1_wr  <= (w_cmd == 2'd1);
         r_s1_adr <= iSUsiAdrs[15:0];
         r_s1_wd  <= iSUsiWd;
      end
   end

   assign w_wr = r_s1_vld & r_s1_wr;
   assign w_rd = r_s1_vld & ~r_s1_wr;

   always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
         for (int k = 0; k < pCsrNum; k++) r_csr[k] <= '0;
         r_we <= '0;
      end else begin
         r_we <= '0;
         for (int k = 0; k < pCsrNum; k++) begin
            if (w_wr && (r_s1_adr == 16'(k))) begin
               r_csr[k] <= r_s1_wd;
               r_we[k]  <= 1'b1;
            end
         end
      end
   end

`ifdef USI_SLAVE_IRQ_EN
   logic [pIrqNum-1:0] r_irq_sts;
   logic [pIrqNum-1:0] r_irq_msk;
   logic [pIrqNum-1:0] w_irq_clr;
   logic               r_irq;

   assign w_irq_clr = (w_wr && (r_s1_adr == lpIrqStsAdr))
                    ? r_s1_wd[pIrqNum-1:0] : '0;

   // Sources are OR-ed in after the W1C clear so a coincident set wins.
   always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
         r_irq_sts <= '0;
         r_irq_msk <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_irq_sts <= (r_irq_sts & ~w_irq_clr) | iIrqSrc;
         if (w_wr && (r_s1_adr == lpIrqMskAdr))
            r_irq_msk <= r_s1_wd[pIrqNum-1:0];
         r_irq <= |(r_irq_sts & r_irq_msk);
      end
   end

   assign oIrq     = r_irq;
   assign w_unused = ^iSUsiAdrs[29:24];
`else
   assign oIrq     = 1'b0;
   assign w_unused = ^{iSUsiAdrs[29:24], iIrqSrc};
`endif

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < pCsrNum; k++)
         if (r_s1_adr == 16'(k)) w_rdata = r_csr[k];
      if (r_s1_adr == lpStsAdr) w_rdata = iStatus;
`ifdef USI_SLAVE_IRQ_EN
      if (r_s1_adr == lpIrqStsAdr) w_rdata = 32'(r_irq_sts);
      if (r_s1_adr == lpIrqMskAdr) w_rdata = 32'(r_irq_msk);
`endif
   end

   // Read bus is zero whenever no response is pending so masters can OR slaves.
   always_ff @(posedge iSysClk) begin
      if (iSysRst) begin
         r_vd <= 1'b0;
         r_rd <= '0;
      end else begin
         r_vd <= w_rd;
         r_rd <= w_rd ? w_rdata : '0;
      end
   end

   for (genvar g = 0; g < pCsrNum; g++) begin : g_q
      assign oCsrQ[32*g +: 32] = r_csr[g];
   end

   assign oCsrWe  = r_we;
   assign oSUsiRd = r_rd;
   assign oSUsiVd = r_vd;

endmodule

// File: tb/tb_usi_slave_csr.sv
// tb_usi_slave_csr: randomized scoreboard bench for usi_slave_csr.
// Expected reads and CSR writes are queued at issue time and checked by a monitor.
module tb_usi_slave_csr;

   logic         clk = 1'b0;
   logic         iSysRst = 1'b1;
   logic [31:0]  iSUsiWd = '0;
   logic [31:0]  iSUsiAdrs = '0;
   logic         iSUsiWCke = 1'b0;
   logic [31:0]  oSUsiRd;
   logic         oSUsiVd;
   logic [255:0] oCsrQ;
   logic [7:0]   oCsrWe;
   logic [31:0]  iStatus = '0;
   logic [3:0]   iIrqSrc = '0;
   logic         oIrq;

   usi_slave_csr #(.pBusAdrs(8'h01), .pCsrNum(8), .pIrqNum(4)) dut (
      .iSysClk(clk), .iSysRst(iSysRst), .iSUsiWd(iSUsiWd),
      .iSUsiAdrs(iSUsiAdrs), .iSUsiWCke(iSUsiWCke), .oSUsiRd(oSUsiRd),
      .oSUsiVd(oSUsiVd), .oCsrQ(oCsrQ), .oCsrWe(oCsrWe),
      .iStatus(iStatus), .iIrqSrc(iIrqSrc), .oIrq(oIrq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   typedef struct { int cyc; logic [31:0] d; } rd_t;
   typedef struct { int cyc; logic [7:0] we; logic [255:0] q; } wr_t;
   rd_t rdq[$];
   wr_t wrq[$];

   logic [31:0] mdl [8];
   logic [3:0]  m_sts = '0;
   logic [3:0]  m_msk = '0;

   task automatic check(string nm, logic [255:0] act, logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] snap();
      logic [255:0] s;
      for (int k = 0; k < 8; k++) s[32*k +: 32] = mdl[k];
      return s;
   endfunction

   function automatic logic [31:0] mdl_rd(logic [15:0] a);
      if (a < 16'd8) return mdl[a[2:0]];
      if (a == 16'h0080) return iStatus;
`ifdef USI_SLAVE_IRQ_EN
      if (a == 16'h0081) return 32'(m_sts);
      if (a == 16'h0082) return 32'(m_msk);
`endif
      return 32'h0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iSUsiWCke = 1'b0;
      iSUsiAdrs = $urandom;
      iSUsiWd   = $urandom;
      step();
   endtask

   task automatic cmd(logic [1:0] c, logic [7:0] bus, logic [15:0] a,
                      logic [31:0] wd);
      iSUsiWCke = 1'b1;
      iSUsiAdrs = {c, 6'($urandom), bus, a};
      iSUsiWd   = wd;
      if (bus == 8'h01) begin
         if (c == 2'd1 && a < 16'd8) begin
            mdl[a[2:0]] = wd;
            wrq.push_back('{cyc + 2, 8'd1 << a[2:0], snap()});
         end else if (c == 2'd2) begin
            rdq.push_back('{cyc + 2, mdl_rd(a)});
         end
`ifdef USI_SLAVE_IRQ_EN
         if (c == 2'd1 && a == 16'h0081) m_sts = (m_sts & ~wd[3:0]) | iIrqSrc;
         if (c == 2'd1 && a == 16'h0082) m_msk = wd[3:0];
`endif
      end
      step();
   endtask

   task automatic do_reset();
      iSUsiWCke = 1'b0;
      iSysRst = 1'b1;
      rdq.delete();
      wrq.delete();
      for (int k = 0; k < 8; k++) mdl[k] = '0;
      m_sts = '0;
      m_msk = '0;
      step();
      step();
      iSysRst = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (oSUsiVd) begin
            if (rdq.size() == 0) check("unexpected_vd", 1, 0);
            else begin
               rd_t e;
               e = rdq.pop_front();
               check("rd_latency", cyc, e.cyc);
               check("rd_data", oSUsiRd, e.d);
            end
         end else begin
            check("rd_idle_zero", oSUsiRd, 0);
         end
         if (oCsrWe != 8'h0) begin
            if (wrq.size() == 0) check("unexpected_we", oCsrWe, 0);
            else begin
               wr_t w;
               w = wrq.pop_front();
               check("we_latency", cyc, w.cyc);
               check("we_onehot", oCsrWe, w.we);
               check("csr_q", oCsrQ, w.q);
            end
         end
      end
   end

   initial begin
      logic [15:0] a;
      logic [1:0]  c;
      logic [7:0]  bus;
      int          sel;
      for (int k = 0; k < 8; k++) mdl[k] = '0;
      step();
      step();
      step();
      iSysRst = 1'b0;
      step();
      check("rst_vd", oSUsiVd, 0);
      check("rst_rd", oSUsiRd, 0);
      check("rst_we", oCsrWe, 0);
      check("rst_q", oCsrQ, 0);
      check("rst_irq", oIrq, 0);
      mon_en = 1'b1;

      cmd(2'd1, 8'h01, 16'h0003, 32'hDEADBEEF);
      idle();
      check("q3_after_wr", oCsrQ[127:96], 32'hDEADBEEF);
      cmd(2'd2, 8'h01, 16'h0003, 32'h0);
      idle();
      idle();

      iStatus = 32'hA5A5_0001;
      idle();
      idle();
      cmd(2'd1, 8'h01, 16'h0005, 32'h1234_5678);
      cmd(2'd2, 8'h01, 16'h0005, 32'h0);
      cmd(2'd2, 8'h01, 16'h0080, 32'h0);
      idle();
      idle();

      cmd(2'd1, 8'h02, 16'h0003, 32'h1111_1111);
      cmd(2'd0, 8'h01, 16'h0003, 32'h2222_2222);
      cmd(2'd3, 8'h01, 16'h0003, 32'h3333_3333);
      cmd(2'd1, 8'h01, 16'h0080, 32'h4444_4444);
      cmd(2'd1, 8'h01, 16'h1003, 32'h5555_5555);
      cmd(2'd2, 8'h02, 16'h0003, 32'h0);
      cmd(2'd2, 8'h01, 16'h0050, 32'h0);
      cmd(2'd2, 8'h01, 16'h1000, 32'h0);
      cmd(2'd2, 8'h01, 16'h0003, 32'h0);
      idle();
      idle();

      idle();
      cmd(2'd2, 8'h01, 16'h0003, 32'h0);
      do_reset();
      check("q_after_rst", oCsrQ, 0);
      idle();
      idle();

`ifdef USI_SLAVE_IRQ_EN
      iIrqSrc = 4'b0100;
      m_sts = m_sts | 4'b0100;
      idle();
      iIrqSrc = 4'b0000;
      idle();
      cmd(2'd1, 8'h01, 16'h0082, 32'h4);
      idle();
      idle();
      idle();
      check("irq_on", oIrq, 1);
      cmd(2'd2, 8'h01, 16'h0081, 32'h0);
      iIrqSrc = 4'b0100;
      cmd(2'd1, 8'h01, 16'h0081, 32'h4);
      idle();
      idle();
      cmd(2'd2, 8'h01, 16'h0081, 32'h0);
      idle();
      idle();
      check("irq_set_wins", oIrq, 1);
      iIrqSrc = 4'b0000;
      idle();
      cmd(2'd1, 8'h01, 16'h0081, 32'h4);
      idle();
      idle();
      idle();
      check("irq_off", oIrq, 0);
      cmd(2'd2, 8'h01, 16'h0081, 32'h0);
      cmd(2'd1, 8'h01, 16'h0082, 32'hFFFF_FFFF);
      cmd(2'd2, 8'h01, 16'h0082, 32'h0);
      cmd(2'd1, 8'h01, 16'h0082, 32'h0);
      idle();
      idle();
`endif

      for (int chunk = 0; chunk < 4; chunk++) begin
         idle();
         idle();
         iStatus = $urandom;
         idle();
         idle();
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 9) < 2) idle();
            else begin
               c   = 2'($urandom_range(0, 9) < 5 ? 1 : 2);
               if ($urandom_range(0, 9) == 0) c = 2'($urandom_range(0, 3));
               bus = ($urandom_range(0, 7) == 0) ? 8'h02 : 8'h01;
               sel = $urandom_range(0, 9);
               if (sel <= 5) a = 16'($urandom_range(0, 7));
               else if (sel == 6) a = 16'($urandom_range(8, 15));
               else if (sel == 7) a = 16'h0080;
               else if (sel == 8) a = 16'h1000 | 16'($urandom_range(0, 7));
               else a = 16'h0081 + 16'($urandom_range(0, 1));
               cmd(c, bus, a, $urandom);
            end
         end
      end

      for (int k = 0; k < 8; k++) cmd(2'd2, 8'h01, 16'(k), 32'h0);
      cmd(2'd2, 8'h01, 16'h0080, 32'h0);
      for (int i = 0; i < 10 && (rdq.size() + wrq.size()) != 0; i++) idle();
      check("drain", 256'(rdq.size() + wrq.size()), 0);
`ifndef USI_SLAVE_IRQ_EN
      check("irq_tied_low", oIrq, 0);
`endif
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/usi_slave_csr.md
Name: usi_slave_csr

Overview:
- Bus slave endpoint for the internal USI bus: the responder counterpart of the master controller.
- Decodes master commands addressed to this block and maintains a bank of RW CSRs, one read-only status word and an optional interrupt block.
- Returns read data and a valid strobe to the master.
- One instance per peripheral block; the master ORs all slave read buses together.

Parameters:
pBusAdrs, 8'h01, bus address this slave answers to (compared with adrs[23:16])
pCsrNum, 8, number of 32-bit RW CSRs (1..16), CSR addresses 0x0000..pCsrNum-1
pIrqNum, 4, number of interrupt sources (1..32), used only with the optional feature

Ports:
iSysClk  in  1  system clock
iSysRst  in  1  synchronous active-high reset
iSUsiWd  in  32  write data from master
iSUsiAdrs  in  32  [31:30] cmd (0 none, 1 write, 2 read, 3 WR reserved); [23:16] bus address; [15:0] CSR address
iSUsiWCke  in  1  command valid
oSUsiRd  out  32  read data; all-zero when oSUsiVd low (OR-able)
oSUsiVd  out  1  read data valid, one-cycle pulse
oCsrQ  out  32*pCsrNum  flattened RW CSR contents, reg k at [32k+31:32k]
oCsrWe  out  pCsrNum  one-hot, one-cycle pulse when reg k is written
iStatus  in  32  read-only status word at CSR 0x0080
iIrqSrc  in  pIrqNum  level interrupt sources
oIrq  out  1  interrupt request to master

Behaviour:
- Clocking: one clock (iSysClk); reset is synchronous and active-high (iSysRst).
- Reset: all CSRs 0, oCsrWe 0, oSUsiRd 0, oSUsiVd 0, oIrq 0, pipeline stages invalid.
- Stage 1 (capture):
  - On a cycle N edge with iSUsiWCke=1, cmd in {1,2} and adrs[23:16]==pBusAdrs, latch cmd, CSR address and data.
  - Otherwise stage 1 is invalid.
  - cmd 0 and cmd 3 are ignored: no write, no response.
- Stage 2 (execute), edge ending cycle N+1:
  - Write: if CSR address < pCsrNum, update the reg, and oCsrWe[k]=1 during cycle N+2. Writes to 0x0080 or unmapped addresses are dropped silently.
  - Read: load oSUsiRd with the addressed value (unmapped -> 0), with oSUsiVd=1 during cycle N+2.
- Latency:
  - Read: 2 cycles from command to data.
  - Write: visible on oCsrQ in cycle N+2.
- Throughput: one command per cycle; back-to-back commands are fully pipelined with no stalls.
- Write at N followed by read of the same address at N+1 returns the new value.
- Commands for other bus addresses never produce oSUsiVd or any state change.
- oSUsiRd is forced to 0 in every cycle where oSUsiVd=0.
- Reset asserted mid-operation: in-flight commands are discarded and no response pulse is produced after reset.
- Address decode compares the full 16-bit CSR address; e.g. 0x1000 does not alias to 0x0000.

Optional Feature:
USI_SLAVE_IRQ_EN
- Defined:
  - 0x0081 is IRQ status. Bit i is set in any cycle where iIrqSrc[i]=1 and is sticky. Writing 1 to bit i clears it (W1C). If set and clear occur in the same cycle, set wins.
  - 0x0082 is IRQ mask, RW, reset 0.
  - oIrq is registered: |(status & mask), one cycle after the status/mask update.
  - Bits at and above pIrqNum read 0.
- Undefined:
  - 0x0081 and 0x0082 behave as unmapped (read 0, writes dropped).
  - oIrq is tied to 0; iIrqSrc is ignored.

Test Plan:
- Reset, then write adrs=0x4001_0003 wd=0xDEADBEEF -> oCsrWe=8'b0000_1000 for 1 cycle at N+2; oCsrQ[127:96]=0xDEADBEEF.
- Read adrs=0x8001_0003 after the above -> oSUsiVd pulse at N+2 with oSUsiRd=0xDEADBEEF; oSUsiRd=0 in all other cycles.
- Write then read of the same reg on consecutive cycles (wd=0x1234_5678), followed by a read of 0x0080 with iStatus=0xA5A5_0001 -> two consecutive Vd pulses returning 0x12345678 then 0xA5A50001.
- Commands with bus address 0x02, cmd 0, cmd 3, and reads of unmapped 0x0050 -> no state change; no Vd except for 0x0050, which returns Vd with data 0.
- Read issued, then iSysRst asserted on the next cycle -> no Vd pulse; all CSRs read 0 afterwards.
- With USI_SLAVE_IRQ_EN: pulse iIrqSrc[2], write mask 0x4 -> oIrq=1; write 0x0081=0x4 while iIrqSrc[2]=1 -> bit stays set; drop the source and write again -> status 0, oIrq=0.
